// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell, LSB first, one bit per clock.
// Optional subtract mode via the SERIAL_ADD_SUB_EN macro (adds the `sub` input).

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] reg_a_r;
   logic [WIDTH-1:0] reg_b_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   logic             fa_s;
   logic             fa_cout;
   logic [WIDTH-1:0] res_next_s;
   logic [WIDTH-1:0] b_load_s;
   logic             c_load_s;

   full_adder u_fa (
      .a    (reg_a_r[0]),
      .b    (reg_b_r[0]),
      .cin  (carry_r),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign res_next_s = {fa_s, res_r[WIDTH-1:1]};

   // Operand B and initial carry as loaded on an accepted start
   always_comb begin
      b_load_s = b;
      c_load_s = cin;
`ifdef SERIAL_ADD_SUB_EN
      if (sub) begin
         b_load_s = ~b;
         c_load_s = 1'b1;
      end else begin
         b_load_s = b;
         c_load_s = cin;
      end
`endif
   end

   // Controller FSM and serial datapath; sum/cout change only on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         reg_a_r <= {WIDTH{1'b0}};
         reg_b_r <= {WIDTH{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  reg_a_r <= a;
                  reg_b_r <= b_load_s;
                  carry_r <= c_load_s;
                  cnt_r   <= {CW{1'b0}};
                  state_r <= SHIFT;
               end else begin
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               reg_a_r <= {1'b0, reg_a_r[WIDTH-1:1]};
               reg_b_r <= {1'b0, reg_b_r[WIDTH-1:1]};
               carry_r <= fa_cout;
               res_r   <= res_next_s;
               cnt_r   <= cnt_r + CW'(1);
               // terminal count ends the operation before the counter can wrap
               if (cnt_r == CW'(WIDTH - 1)) begin
                  sum_r   <= res_next_s;
                  cout_r  <= fa_cout;
                  state_r <= DONE;
               end else begin
                  state_r <= SHIFT;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_r == SHIFT);
   assign done = (state_r == DONE);
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
`ifdef SERIAL_ADD_SUB_EN
   logic       sub;
`endif
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int n_vec = 0;
   int n_err = 0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_sub(input logic sb);
`ifdef SERIAL_ADD_SUB_EN
      sub = sb;
`endif
   endtask

   // One full operation; hs/hc are the previous result that must hold while busy
   task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                         input logic sb, input logic [7:0] es, input logic ec,
                         input logic [7:0] hs, input logic hc);
      @(negedge clk);
      a = aa; b = bb; cin = cc; set_sub(sb); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~aa; b = ~bb; cin = ~cc; set_sub(1'b0);
      for (int i = 0; i < 8; i++) begin
         check("busy_hi", {31'd0, busy}, 32'd1);
         check("done_lo", {31'd0, done}, 32'd0);
         check("sum_hold", {24'd0, sum}, {24'd0, hs});
         check("cout_hold", {31'd0, cout}, {31'd0, hc});
         @(posedge clk); #1;
      end
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("sum", {24'd0, sum}, {24'd0, es});
      check("cout", {31'd0, cout}, {31'd0, ec});
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("sum_kept", {24'd0, sum}, {24'd0, es});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; set_sub(1'b0);
      #3;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {24'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      run_op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 8'h00, 1'b1);

      // start held high: no re-capture during SHIFT, back-to-back from DONE
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 8'h01; b = 8'h01;
      for (int i = 0; i < 8; i++) begin
         check("b2b_busy1", {31'd0, busy}, 32'd1);
         check("b2b_hold1", {24'd0, sum}, 32'h97);
         @(posedge clk); #1;
      end
      check("b2b_done1", {31'd0, done}, 32'd1);
      check("b2b_sum1", {24'd0, sum}, 32'h46);
      check("b2b_cout1", {31'd0, cout}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("b2b_busy2", {31'd0, busy}, 32'd1);
         check("b2b_hold2", {24'd0, sum}, 32'h46);
         @(posedge clk); #1;
      end
      check("b2b_done2", {31'd0, done}, 32'd1);
      check("b2b_sum2", {24'd0, sum}, 32'h02);
      check("b2b_cout2", {31'd0, cout}, 32'd0);
      @(posedge clk); #1;
      check("b2b_idle", {31'd0, busy | done}, 32'd0);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("mid_busy_pre", {31'd0, busy}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_sum", {24'd0, sum}, 32'd0);
      check("mid_rst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
      run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h02, 1'b0);
      run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F, 1'b1);
      run_op(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 8'hFF, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
